// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, transmitter and status signals of the UART
// transmit arbiter. The master modport is the client/transmitter side, the
// slave modport is the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           tx_data;
  logic                 tx_write_enable;
  logic                 tx_active;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 timeout_err;

  modport master (
    output req, req_data, req_lock, tx_active,
    input  ack, tx_data, tx_write_enable, busy, grant_id, timeout_err
  );

  modport slave (
    input  req, req_data, req_lock, tx_active,
    output ack, tx_data, tx_write_enable, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ
// byte requesters. One byte at a time: grant, load, wait for the frame to
// start (with a start timeout), wait for the frame to end.
// Optional feature: define UART_ARB_LOCK_EN to let the last grantee keep the
// transmitter while it holds req_lock together with req.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input logic             clk_50mhz,
  input logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [7:0]     start_cnt;
  logic [7:0]     start_cnt_next;
  logic [IDW-1:0] winner;
  logic           found;
  int             scan_idx;

  assign start_cnt_next = start_cnt + 8'd1;

`ifndef UART_ARB_LOCK_EN
  logic lock_unused;
  assign lock_unused = &bus.req_lock;
`endif

  // Pick the next requester scanning upward from last+1 with wrap-around.
  always_comb begin
    winner   = last;
    found    = 1'b0;
    scan_idx = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_idx = int'(last) + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && bus.req[scan_idx]) begin
        winner = IDW'(scan_idx);
        found  = 1'b1;
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (bus.req_lock[last] && bus.req[last]) winner = last;
`endif
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      last                <= IDW'(NUM_REQ - 1);
      start_cnt           <= 8'd0;
      bus.tx_data         <= 8'h00;
      bus.grant_id        <= '0;
      bus.tx_write_enable <= 1'b0;
      bus.ack             <= '0;
      bus.busy            <= 1'b0;
      bus.timeout_err     <= 1'b0;
    end else begin
      bus.tx_write_enable <= 1'b0;
      bus.ack             <= '0;
      bus.timeout_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != '0 && !bus.tx_active) begin
            bus.grant_id        <= winner;
            bus.tx_data         <= bus.req_data[8*int'(winner) +: 8];
            bus.tx_write_enable <= 1'b1;
            bus.ack             <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            bus.busy            <= 1'b1;
            last                <= winner;
            state               <= LOAD;
          end
        end
        LOAD: begin
          start_cnt <= 8'd0;
          state     <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.tx_active) begin
            state <= WAIT_DONE;
          end else if (start_cnt_next == 8'(START_TIMEOUT - 1)) begin
            start_cnt       <= start_cnt_next;
            bus.timeout_err <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            start_cnt <= start_cnt_next;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_active) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: bench for uart_tx_arbiter with a simple transmitter
// model that raises tx_active a few cycles after each write_enable.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 16;

  logic clk_50mhz = 1'b0;
  logic rst_n     = 1'b0;

  always #10 clk_50mhz = ~clk_50mhz;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] data;
    int                   exp_gid;
    logic [7:0]           exp_data;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;

  int tx_delay = 2;
  int tx_len   = 10;
  bit tx_mute  = 1'b0;

  int we_count = 0;
  int ack_count[NUM_REQ];

  logic [NUM_REQ-1:0]   cur_req, prev_req;
  logic [7:0]           lane_data[NUM_REQ];
  logic [7:0]           prev_data[NUM_REQ];
  logic [8*NUM_REQ-1:0] fair_word;
  int model_last, exp_w, scan_idx, grants, k, ones, we0, a2;
  int lock_exp[6];
  bit early, ok;

  // Transmitter model: frame starts tx_delay cycles after a write, lasts tx_len cycles.
  initial begin
    bus.tx_active = 1'b0;
    forever begin
      @(posedge clk_50mhz);
      #1;
      if (bus.tx_write_enable && !tx_mute) begin
        repeat (tx_delay) @(posedge clk_50mhz);
        #1 bus.tx_active = 1'b1;
        repeat (tx_len) @(posedge clk_50mhz);
        #1 bus.tx_active = 1'b0;
      end
    end
  end

  // Event counters for write pulses and acks.
  initial foreach (ack_count[i]) ack_count[i] = 0;
  always @(negedge clk_50mhz) begin
    if (rst_n) begin
      if (bus.tx_write_enable) we_count++;
      for (int i = 0; i < NUM_REQ; i++) if (bus.ack[i]) ack_count[i]++;
    end
  end

  // Hard stop if something hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_50mhz);
      if (bus.tx_write_enable) seen = 1'b1;
    end
    check({tag, "_grant_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk_50mhz);
      if (!bus.busy && !bus.tx_active) done = 1'b1;
    end
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    bus.req      = '0;
    bus.req_lock = '0;
    bus.req_data = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    rst_n = 1'b1;
    @(negedge clk_50mhz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'h00);
    check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    check({tag, "_we"}, 32'(bus.tx_write_enable), 32'd0);
    check({tag, "_ack"}, 32'(bus.ack), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_timeout"}, 32'(bus.timeout_err), 32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v, input int n);
    bus.req_data = v.data;
    bus.req      = v.req;
    @(negedge clk_50mhz);
    check_output(v, n);
  endtask

  task automatic check_output(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    check({tag, "_we"}, 32'(bus.tx_write_enable), 32'd1);
    check({tag, "_gid"}, 32'(bus.grant_id), 32'(v.exp_gid));
    check({tag, "_data"}, 32'(bus.tx_data), 32'(v.exp_data));
    check({tag, "_ack"}, 32'(bus.ack), 32'd1 << v.exp_gid);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.req = '0;
    @(negedge clk_50mhz);
    check({tag, "_we_pulse"}, 32'(bus.tx_write_enable), 32'd0);
    check({tag, "_ack_pulse"}, 32'(bus.ack), 32'd0);
    wait_idle(tag);
  endtask

  initial begin
    bus.req      = '0;
    bus.req_lock = '0;
    bus.req_data = '0;

    vecs[0] = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h4433_2211, 1, 8'h22};
    vecs[2] = '{4'b1001, 32'h4433_2211, 3, 8'h44};
    vecs[3] = '{4'b1111, 32'h4433_2211, 0, 8'h11};
    vecs[4] = '{4'b0100, 32'h4433_2211, 2, 8'h33};
    vecs[5] = '{4'b0011, 32'h4433_2211, 0, 8'h11};
    vecs[6] = '{4'b1000, 32'hFE00_0000, 3, 8'hFE};
    vecs[7] = '{4'b0110, 32'h00C3_3C00, 1, 8'h3C};

`ifdef UART_ARB_LOCK_EN
    lock_exp = '{0, 1, 1, 1, 0, 1};
`else
    lock_exp = '{0, 1, 0, 1, 0, 1};
`endif

    // Reset state.
    repeat (3) @(negedge clk_50mhz);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_50mhz);
    check_reset_outputs("post_reset");

    // Table of single-byte grants, rotation carried from vector to vector.
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);

    // Fairness: all requesters held high for 8 bytes.
    do_reset();
    fair_word    = 32'h4433_2211;
    bus.req_data = fair_word;
    we0 = we_count;
    a2  = ack_count[0] + ack_count[1] + ack_count[2] + ack_count[3];
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_grant($sformatf("fair%0d", i));
      check($sformatf("fair%0d_gid", i), 32'(bus.grant_id), 32'(i % 4));
      check($sformatf("fair%0d_data", i), 32'(bus.tx_data), 32'(fair_word[8*(i%4) +: 8]));
      if (i == 7) bus.req = '0;
    end
    wait_idle("fair");
    check("fair_we_count", 32'(we_count - we0), 32'd8);
    check("fair_ack_count", 32'(ack_count[0] + ack_count[1] + ack_count[2] + ack_count[3] - a2), 32'd8);

    // Start timeout: transmitter never answers.
    tx_mute      = 1'b1;
    bus.req_data = 32'h0000_005A;
    bus.req      = 4'b0001;
    wait_grant("tmo");
    bus.req = '0;
    k = 0;
    for (int i = 0; i < 100 && !bus.timeout_err; i++) begin
      @(negedge clk_50mhz);
      k++;
    end
    check("tmo_latency", 32'(k), 32'(START_TIMEOUT));
    check("tmo_busy_low", 32'(bus.busy), 32'd0);
    tx_mute      = 1'b0;
    bus.req_data = 32'h0000_7700;
    bus.req      = 4'b0010;
    @(negedge clk_50mhz);
    check("tmo_err_pulse", 32'(bus.timeout_err), 32'd0);
    check("tmo_next_we", 32'(bus.tx_write_enable), 32'd1);
    check("tmo_next_gid", 32'(bus.grant_id), 32'd1);
    check("tmo_next_data", 32'(bus.tx_data), 32'h77);
    bus.req = '0;
    wait_idle("tmo");

    // Reset in the middle of a frame.
    tx_len       = 20;
    bus.req_data = 32'h0012_0000;
    bus.req      = 4'b0100;
    wait_grant("rstmid");
    bus.req = '0;
    for (int i = 0; i < 20 && !bus.tx_active; i++) @(negedge clk_50mhz);
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    bus.req      = 4'b1111;
    bus.req_data = 32'h4433_2211;
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    check("rstmid_frame_active", 32'(bus.tx_active), 32'd1);
    early = 1'b0;
    for (int i = 0; i < 100 && bus.tx_active; i++) begin
      @(negedge clk_50mhz);
      if (bus.tx_write_enable && bus.tx_active) early = 1'b1;
    end
    check("rstmid_no_early_grant", 32'(early), 32'd0);
    wait_grant("rstmid_after");
    check("rstmid_first_gid", 32'(bus.grant_id), 32'd0);
    bus.req = '0;
    wait_idle("rstmid");
    tx_len = 10;

    // Lock hint: requesters 0 and 1, lock raised by 1 after its first grant.
    do_reset();
    bus.req_data = 32'h0000_B1B0;
    bus.req      = 4'b0011;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      wait_grant($sformatf("lock%0d", i));
      check($sformatf("lock%0d_gid", i), 32'(bus.grant_id), 32'(lock_exp[i]));
      if (bus.grant_id == 1) begin
        ones++;
        if (ones == 1) bus.req_lock = 4'b0010;
        if (ones == 3) bus.req_lock = 4'b0000;
      end
      if (i == 5) bus.req = '0;
    end
    bus.req_lock = '0;
    wait_idle("lock");

    // Withdrawal: req[2] pulses while another frame is on the line.
    bus.req_data = 32'h00CC_0011;
    bus.req      = 4'b0001;
    wait_grant("wdraw");
    bus.req = '0;
    for (int i = 0; i < 20 && !bus.tx_active; i++) @(negedge clk_50mhz);
    we0 = we_count;
    a2  = ack_count[2];
    bus.req = 4'b0100;
    repeat (2) @(negedge clk_50mhz);
    bus.req = '0;
    wait_idle("wdraw");
    repeat (5) @(negedge clk_50mhz);
    check("wdraw_no_we", 32'(we_count - we0), 32'd0);
    check("wdraw_no_ack2", 32'(ack_count[2] - a2), 32'd0);

    // Randomized traffic against a transaction-level round-robin model.
    do_reset();
    model_last = NUM_REQ - 1;
    grants     = 0;
    cur_req    = '0;
    prev_req   = '0;
    foreach (lane_data[i]) begin
      lane_data[i] = 8'h00;
      prev_data[i] = 8'h00;
    end
    for (int cyc = 0; cyc < 20000 && grants < 60; cyc++) begin
      @(negedge clk_50mhz);
      if (bus.tx_write_enable) begin
        exp_w = -1;
        for (int off = 1; off <= NUM_REQ; off++) begin
          scan_idx = (model_last + off) % NUM_REQ;
          if (exp_w < 0 && prev_req[scan_idx]) exp_w = scan_idx;
        end
        check("rand_grant_expected", 32'(exp_w >= 0), 32'd1);
        if (exp_w >= 0) begin
          check($sformatf("rand%0d_gid", grants), 32'(bus.grant_id), 32'(exp_w));
          check($sformatf("rand%0d_data", grants), 32'(bus.tx_data), 32'(prev_data[exp_w]));
          check($sformatf("rand%0d_ack", grants), 32'(bus.ack), 32'd1 << exp_w);
          model_last = exp_w;
          grants++;
          if ($urandom_range(0, 1) == 1) lane_data[exp_w] = 8'($urandom);
          else cur_req[exp_w] = 1'b0;
          tx_delay = $urandom_range(1, 4);
          tx_len   = $urandom_range(1, 12);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!cur_req[i] && $urandom_range(0, 3) == 0) begin
          cur_req[i]   = 1'b1;
          lane_data[i] = 8'($urandom);
        end
      end
      bus.req = cur_req;
      for (int i = 0; i < NUM_REQ; i++) bus.req_data[8*i +: 8] = lane_data[i];
      prev_req = cur_req;
      foreach (lane_data[i]) prev_data[i] = lane_data[i];
    end
    check("rand_grant_total", 32'(grants), 32'd60);
    bus.req = '0;
    wait_idle("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `NUM_REQ` byte requesters. It sits between the client logic and the transmitter's `data_in`/`write_enable`/`tx_active` pins. It sequences exactly one byte at a time: grant, load, wait for the frame to start, wait for the frame to finish. It also recovers if the transmitter never starts a frame.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 16: clock cycles to wait for `tx_active` to rise after a load before aborting, 2..255.
- `clk_50mhz`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester byte-pending flag.
- `req_data`  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- `req_lock`  in  NUM_REQ  hold-grant hint; used only when `UART_ARB_LOCK_EN` is defined.
- `ack`  out  NUM_REQ  one-cycle pulse: the byte for requester i has been handed to the transmitter.
- `tx_data`  out  8  to transmitter `data_in`; registered.
- `tx_write_enable`  out  1  to transmitter `write_enable`; single-cycle pulse.
- `tx_active`  in  1  from transmitter; high while a frame is on the line.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  IDW  index of the current or last grantee. IDW = max(1, clog2(NUM_REQ)).
- `timeout_err`  out  1  one-cycle pulse when the start timeout fires.

## Operation
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE, with `req` nonzero:
  - Choose the winner by round-robin, scanning from (last+1) mod NUM_REQ upward with wrap.
  - Register `grant_id` = winner.
  - Register `tx_data` = that requester's slice of `req_data`.
  - Update last = winner. Go to LOAD.
- IDLE, with `req` zero: stay in IDLE.
- LOAD:
  - Assert `tx_write_enable` = 1 and `ack[grant_id]` = 1 for this cycle only.
  - Clear the timeout counter. Go to WAIT_START.
- WAIT_START:
  - `tx_active` = 1: go to WAIT_DONE.
  - Otherwise increment the counter. When counter = START_TIMEOUT-1, pulse `timeout_err` and go to IDLE. The byte is dropped and not retried.
- WAIT_DONE: when `tx_active` = 0, go to IDLE.
- Requester contract:
  - Hold `req[i]` and its data stable until `ack[i]`.
  - `req[i]` still high in the cycle after `ack[i]` means a new byte.
  - Deasserting `req[i]` before it is granted is legal; nothing is sent.
- Changes to `req`/`req_data` after the IDLE sampling cycle do not affect the byte already captured.
- Reset values:
  - State IDLE, last = NUM_REQ-1, so requester 0 wins first.
  - `tx_data` = 8'h00, `grant_id` = 0.
  - `tx_write_enable`, `ack`, `busy`, `timeout_err` = 0.
  - Counter = 0.
- Reset mid-frame: the FSM returns to IDLE at once. The transmitter is not touched and finishes its frame on its own. After reset release the arbiter waits for `tx_active` = 0 before the next grant; IDLE grants only when `tx_active` = 0.

## Timing
- Grant latency: `req` sampled high in IDLE at cycle N → `tx_write_enable`/`ack` at cycle N+1.
- `busy` rises at N+1 and falls in the cycle after `tx_active` is seen low.
- Back-to-back bytes: at least one IDLE cycle between the end of a frame and the next LOAD.
- `tx_data` is valid from LOAD until the next grant.
- `timeout_err` asserts exactly START_TIMEOUT cycles after the LOAD cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - In IDLE, if `req_lock[last]` and `req[last]` are both high, `last` wins again regardless of rotation.
  - This lets a requester send a multi-byte message without interleaving.
  - A timeout does not clear the lock.
- `UART_ARB_LOCK_EN` undefined: `req_lock` is ignored and arbitration is pure round-robin.

## Test plan
- Single byte: `req` = 4'b0001, data0 = 8'hA5, `tx_active` model rises 2 cycles after write and lasts 10 cycles → one `tx_write_enable` with `tx_data` = A5, `ack[0]` one cycle, `busy` low after the frame.
- Fairness: `req` = 4'b1111 held continuously for 8 bytes → grant order 0,1,2,3,0,1,2,3 and one `ack` per byte.
- Timeout: `tx_active` held 0 after LOAD → `timeout_err` exactly 16 cycles after LOAD, FSM back in IDLE, next request served normally.
- Reset mid-frame: `rst_n` low during WAIT_DONE while `tx_active` = 1 → outputs at reset values; no grant until `tx_active` falls; then requester 0 wins.
- Lock (macro on): `req` = 4'b0011, `req_lock[1]` = 1 after the first grant to 1 → three consecutive grants to 1, then 0 once lock drops. Macro off: alternating 1,0.
- Withdrawal: `req[2]` pulsed high then low while another frame is in WAIT_DONE → no `ack[2]` and no extra `tx_write_enable`.
